// File: rtl/char_buf_writer.sv
// char_buf_writer: text-cursor engine turning an ASCII byte stream into character-buffer cell writes
// Ports: clk/rst (async active-high); in_char/in_val/in_rdy byte handshake;
// wr_en/wr_addr/wr_data cell write strobe (row*COLS+col); cur_col/cur_row cursor; busy while clearing.
// Optional: define CHAR_BUF_WRITER_BKSP_EN to enable 0x08 backspace (erase left, no row wrap).
module char_buf_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int AW = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_char,
    input  logic          in_val,
    output logic          in_rdy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          busy
);
`ifdef CHAR_BUF_WRITER_BKSP_EN
    localparam bit BKSP = 1'b1;
`else
    localparam bit BKSP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;
    state_t state, state_n;
    logic [AW-1:0] clr_cnt, cnt_n, addr_n, row_base;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic [7:0]    data_n;
    logic          we_n, brk;
    assign in_rdy   = state == IDLE;
    assign busy     = !in_rdy;
    assign row_base = AW'(cur_row) * AW'(COLS);
    always_comb begin
        state_n = state;
        col_n   = cur_col;
        row_n   = cur_row;
        cnt_n   = clr_cnt;
        we_n    = 1'b0;
        addr_n  = wr_addr;
        data_n  = 8'h20;
        brk     = 1'b0;
        case (state)
            IDLE: if (in_val) begin
                if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                    we_n   = 1'b1;
                    addr_n = row_base + AW'(cur_col);
                    data_n = in_char;
                    brk    = cur_col == CW'(COLS - 1);
                    col_n  = brk ? cur_col : cur_col + CW'(1);
                end else if (in_char == 8'h0A) begin
                    brk = 1'b1;
                end else if (in_char == 8'h0D) begin
                    col_n = '0;
                end else if (in_char == 8'h0C) begin
                    col_n   = '0;
                    row_n   = '0;
                    cnt_n   = '0;
                    state_n = CLR_ALL;
                end else if (BKSP && in_char == 8'h08 && cur_col != '0) begin
                    col_n  = cur_col - CW'(1);
                    we_n   = 1'b1;
                    addr_n = row_base + AW'(col_n);
                end
                if (brk) begin
                    col_n   = '0;
                    row_n   = cur_row == RW'(ROWS - 1) ? '0 : cur_row + RW'(1);
                    cnt_n   = '0;
                    state_n = CLR_LINE;
                end
            end
            CLR_LINE: begin
                we_n    = 1'b1;
                addr_n  = row_base + clr_cnt;
                cnt_n   = clr_cnt + AW'(1);
                state_n = clr_cnt == AW'(COLS - 1) ? IDLE : CLR_LINE;
            end
            CLR_ALL: begin
                we_n    = 1'b1;
                addr_n  = clr_cnt;
                cnt_n   = clr_cnt + AW'(1);
                state_n = clr_cnt == AW'(COLS * ROWS - 1) ? IDLE : CLR_ALL;
            end
            default: begin
                state_n = CLR_ALL;
                cnt_n   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLR_ALL;
            cur_col <= '0;
            cur_row <= '0;
            clr_cnt <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            cur_col <= col_n;
            cur_row <= row_n;
            clr_cnt <= cnt_n;
            wr_en   <= we_n;
            wr_addr <= addr_n;
            wr_data <= data_n;
        end
    end
endmodule

// File: doc/char_buf_writer.md
CHAR_BUF_WRITER -- requirements
Module: char_buf_writer

Interface
REQ-001: Parameter COLS, default 80, text columns per row.
REQ-002: Parameter ROWS, default 60, text rows per screen.
REQ-003: Widths are fixed as CW = ceil(log2(COLS)), RW = ceil(log2(ROWS)) and AW = ceil(log2(COLS*ROWS)).
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, asynchronous, active-high.
REQ-006: in_char  input  8  ASCII byte offered by producer.
REQ-007: in_val  input  1  in_char valid.
REQ-008: in_rdy  output  1  block can accept; transfer when in_val and in_rdy are both high on a clock edge.
REQ-009: wr_en  output  1  character-buffer write strobe, one cell per cycle, no backpressure.
REQ-010: wr_addr  output  AW  cell address = row*COLS + col.
REQ-011: wr_data  output  8  ASCII byte written to the cell.
REQ-012: cur_col  output  CW and cur_row  output  RW  current cursor position.
REQ-013: busy  output  1  high while in a clear state.

Function
REQ-014: FSM states are IDLE, CLR_LINE and CLR_ALL; in_rdy = (state == IDLE); busy = !in_rdy.
REQ-015: All outputs are registered; an accepted byte produces its write (if any) on the wr_* outputs in the following cycle (latency 1).
REQ-016: Printable byte 0x20-0x7E: write it at (cur_row, cur_col); if cur_col < COLS-1 then col+1, else perform a line break.
REQ-017: 0x0A (LF): perform a line break with no character write.
REQ-018: 0x0D (CR): col = 0, no write.
REQ-019: 0x0C (FF): cursor = (0,0), enter CLR_ALL.
REQ-020: Any other byte is accepted and dropped: no write, no cursor change.
REQ-021: Line break: col = 0; row = row+1, wrapping from ROWS-1 to 0; enter CLR_LINE for the new row.
REQ-022: CLR_LINE writes 0x20 to cols 0..COLS-1 of the cursor row in ascending order, one per cycle, then returns to IDLE (COLS cycles with in_rdy low).
REQ-023: CLR_ALL writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, then returns to IDLE.
REQ-024: wr_en is low in any cycle that has no write; wr_addr and wr_data are don't-care when wr_en is low.
REQ-025: The cursor never leaves the range 0..COLS-1 / 0..ROWS-1.
REQ-026: in_val asserted while in_rdy is low causes no transfer; the producer holds the byte.
REQ-027: Back-to-back printable bytes are accepted every cycle with no bubble unless a line break occurs.

Reset
REQ-028: On rst assertion, immediately: state = CLR_ALL, cursor = (0,0), wr_en = 0, clear counter = 0, in_rdy = 0, busy = 1.
REQ-029: After rst deasserts, the block runs a full CLR_ALL sequence before the first in_rdy.
REQ-030: rst asserted mid-CLR_LINE or mid-CLR_ALL aborts that sequence and restarts per REQ-028.

Configuration
REQ-031: Macro CHAR_BUF_WRITER_BKSP_EN controls backspace handling.
REQ-032: With CHAR_BUF_WRITER_BKSP_EN defined, 0x08 is handled as follows: if cur_col > 0, col-1 and write 0x20 at the new position; if col = 0, no action (no reverse row wrap).
REQ-033: Without CHAR_BUF_WRITER_BKSP_EN, 0x08 falls under REQ-020 (dropped).

Verification
REQ-034: Reset, then idle (defaults 80x60) -> 4800 writes of 0x20 to addresses 0..4799, then in_rdy = 1 and cursor (0,0).
REQ-035: After init, send "Hi" -> writes (0,0x48) then (1,0x69), one cycle after each accept; cursor (0,2).
REQ-036: Cursor (5,79), send 'Z' -> write addr 479 = 0x5A; cursor (6,0); 80 writes of 0x20 to addrs 480..559; in_rdy low for 80 cycles.
REQ-037: Cursor (59,10), send 0x0A -> cursor (0,0); addrs 0..79 cleared; no write to addr 4730.
REQ-038: Cursor (2,3), send 0x08 -> with macro: write addr 162 = 0x20, cursor (2,2); without macro: no write, cursor (2,3).
REQ-039: rst pulsed during CLR_ALL at addr 1000 -> wr_en drops immediately; the clear sequence restarts at addr 0 after deassertion.
